alu_arith_unit: RTL and testbench

- Registered arithmetic slice of the CPU ALU.
- Performs three operations on the accumulator (AC) and data register (DR) operands:
  - ADD: AC + DR
  - ASHL: arithmetic shift-left of DR
  - COMP2: two's complement of DR
- Result, carry/extend flag E and a zero flag are captured on the clock edge and held until the next accepted operation.
- Sits between the AC/DR registers and the AC write-back path; E feeds the CPU's E flip-flop.

---
 rtl/alu_pkg.sv | 10 +
 rtl/alu_arith_core.sv | 24 ++
 rtl/alu_arith_unit.sv | 53 +++++
 tb/tb_alu_arith_unit.sv | 98 +++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared width default, opcode constants and opcode legality check for the arithmetic ALU slice
package alu_pkg;
  localparam int ALU_WIDTH = 8;
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_ASHL = 3'b001;
  localparam logic [2:0] OP_COMP2 = 3'b110;
  function automatic logic op_legal(input logic [2:0] op);
    return op == OP_ADD || op == OP_ASHL || op == OP_COMP2;
  endfunction
endpackage

// File: rtl/alu_arith_core.sv
// alu_arith_core: combinational ADD/ASHL/COMP2 datapath producing next result, next e and opcode legality
module alu_arith_core
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] ac,
  input  logic [WIDTH-1:0] dr,
  input  logic             e_in,
  output logic [WIDTH-1:0] res,
  output logic             e_out,
  output logic             legal
);
  logic [WIDTH:0] sum;
  logic [WIDTH-1:0] neg;
  always_comb begin
    sum = {1'b0, ac} + {1'b0, dr};
    neg = ~dr + {{(WIDTH-1){1'b0}}, 1'b1};
    res = op == OP_ADD ? sum[WIDTH-1:0] : op == OP_ASHL ? {dr[WIDTH-2:0], 1'b0} : neg;
    e_out = op == OP_ADD ? sum[WIDTH] : op == OP_ASHL ? dr[WIDTH-1] : e_in;
    legal = op_legal(op);
  end
endmodule

// File: rtl/alu_arith_unit.sv
// alu_arith_unit: registered arithmetic ALU slice with result, e, zero and out_valid outputs
module alu_arith_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] ac,
  input  logic [WIDTH-1:0] dr,
  output logic [WIDTH-1:0] result,
  output logic             e,
  output logic             zero,
  output logic             out_valid
);
  logic [WIDTH-1:0] result_q, result_d, core_res;
  logic e_q, e_d, zero_q, zero_d, valid_q, valid_d, core_e, legal, accept;
  alu_arith_core #(.WIDTH(WIDTH)) u_core (
    .op(op),
    .ac(ac),
    .dr(dr),
    .e_in(e_q),
    .res(core_res),
    .e_out(core_e),
    .legal(legal)
  );
  always_comb begin
    accept = in_valid && legal;
    result_d = accept ? core_res : result_q;
    e_d = accept ? core_e : e_q;
    zero_d = accept ? core_res == '0 : zero_q;
    valid_d = accept;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      e_q <= 1'b0;
      zero_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      result_q <= result_d;
      e_q <= e_d;
      zero_q <= zero_d;
      valid_q <= valid_d;
    end
  end
  assign result = result_q;
  assign e = e_q;
  assign zero = zero_q;
  assign out_valid = valid_q;
endmodule

// File: tb/tb_alu_arith_unit.sv
// tb_alu_arith_unit: table-driven self-checking bench for alu_arith_unit
module tb_alu_arith_unit;
  localparam int W = 8;
  typedef struct {
    logic r;
    logic v;
    logic [2:0] op;
    logic [W-1:0] ac;
    logic [W-1:0] dr;
    logic [W-1:0] x_res;
    logic x_e;
    logic x_z;
    logic x_ov;
    string name;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic [2:0] op = 3'b000;
  logic [W-1:0] ac = '0;
  logic [W-1:0] dr = '0;
  logic [W-1:0] result;
  logic e, zero, out_valid;
  int checks = 0;
  int errors = 0;
  logic primed = 1'b0;
  logic [W-1:0] last_res = '0;
  vec_t tbl[$];
  alu_arith_unit #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .op(op),
    .ac(ac),
    .dr(dr),
    .result(result),
    .e(e),
    .zero(zero),
    .out_valid(out_valid)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", n, got, exp);
    end
  endtask
  task automatic step(input vec_t t);
    @(negedge clk);
    rst = t.r;
    in_valid = t.v;
    op = t.op;
    ac = t.ac;
    dr = t.dr;
    #1;
    if (primed) chk({t.name, "_nocomb"}, result, last_res);
    @(posedge clk);
    #1;
    chk({t.name, "_res"}, result, t.x_res);
    chk({t.name, "_e"}, W'(e), W'(t.x_e));
    chk({t.name, "_zero"}, W'(zero), W'(t.x_z));
    chk({t.name, "_ov"}, W'(out_valid), W'(t.x_ov));
    last_res = t.x_res;
    primed = 1'b1;
  endtask
  initial begin
    tbl.push_back('{1'b1, 1'b1, 3'b000, 8'hC1, 8'hA3, 8'h00, 1'b0, 1'b1, 1'b0, "rst_a"});
    tbl.push_back('{1'b1, 1'b1, 3'b000, 8'hC1, 8'hA3, 8'h00, 1'b0, 1'b1, 1'b0, "rst_b"});
    tbl.push_back('{1'b0, 1'b1, 3'b000, 8'hC1, 8'hA3, 8'h64, 1'b1, 1'b0, 1'b1, "add_c1_a3"});
    tbl.push_back('{1'b0, 1'b1, 3'b000, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b1, "add_ff_01"});
    tbl.push_back('{1'b0, 1'b1, 3'b000, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0, 1'b1, "add_01_02"});
    tbl.push_back('{1'b0, 1'b1, 3'b001, 8'h00, 8'hB1, 8'h62, 1'b1, 1'b0, 1'b1, "ashl_b1"});
    tbl.push_back('{1'b0, 1'b1, 3'b001, 8'hFF, 8'h41, 8'h82, 1'b0, 1'b0, 1'b1, "ashl_41"});
    tbl.push_back('{1'b0, 1'b1, 3'b001, 8'h00, 8'h80, 8'h00, 1'b1, 1'b1, 1'b1, "ashl_80"});
    tbl.push_back('{1'b0, 1'b1, 3'b000, 8'hC1, 8'hA3, 8'h64, 1'b1, 1'b0, 1'b1, "add_preload_e"});
    tbl.push_back('{1'b0, 1'b1, 3'b110, 8'h00, 8'h9A, 8'h66, 1'b1, 1'b0, 1'b1, "comp2_9a"});
    tbl.push_back('{1'b0, 1'b1, 3'b110, 8'h55, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, "comp2_00"});
    tbl.push_back('{1'b0, 1'b1, 3'b110, 8'h00, 8'h80, 8'h80, 1'b1, 1'b0, 1'b1, "comp2_80"});
    tbl.push_back('{1'b0, 1'b1, 3'b000, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0, 1'b1, "add_clear_e"});
    tbl.push_back('{1'b0, 1'b1, 3'b110, 8'hFF, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b1, "comp2_ff_e0"});
    tbl.push_back('{1'b0, 1'b0, 3'b000, 8'hFF, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, "idle"});
    tbl.push_back('{1'b0, 1'b1, 3'b010, 8'hFF, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, "bad_010"});
    tbl.push_back('{1'b0, 1'b1, 3'b011, 8'hFF, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, "bad_011"});
    tbl.push_back('{1'b0, 1'b1, 3'b111, 8'h00, 8'h80, 8'h01, 1'b0, 1'b0, 1'b0, "bad_111"});
    tbl.push_back('{1'b0, 1'b1, 3'b100, 8'h00, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0, "bad_100"});
    tbl.push_back('{1'b0, 1'b1, 3'b101, 8'h80, 8'h80, 8'h01, 1'b0, 1'b0, 1'b0, "bad_101"});
    foreach (tbl[i]) step(tbl[i]);
    step('{1'b0, 1'b1, 3'b000, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0, 1'b1, "tp_add"});
    step('{1'b0, 1'b1, 3'b001, 8'h00, 8'h81, 8'h02, 1'b1, 1'b0, 1'b1, "tp_ashl"});
    step('{1'b0, 1'b1, 3'b110, 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b1, "tp_comp2"});
    step('{1'b1, 1'b1, 3'b000, 8'h7F, 8'h01, 8'h00, 1'b0, 1'b1, 1'b0, "mid_rst"});
    step('{1'b0, 1'b1, 3'b000, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1, "post_rst_add"});
    step('{1'b0, 1'b0, 3'b000, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b0, "post_rst_idle"});
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
